multicycle_rv32_core: RTL
=========================

# multicycle_rv32_core

Multi-cycle RV32I integer core that replaces the single-cycle datapath skeleton. It owns its own PC, register file, decoder, full ALU and branch unit, and talks to a unified instruction/data memory over a single req/ready bus. Each instruction runs through a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. Register count and reset vector are parametrised, so the same RTL builds RV32I (32 regs) and RV32E (16 regs) variants for the inventory-system SoC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E); rd/rs index ≥ NUM_REGS is illegal
- clk  input  1  core clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- mem_req  output  1  bus request, held until accepted
- mem_we  output  1  1 = store word, 0 = read
- mem_addr  output  32  word address; bits [1:0] always 0
- mem_wdata  output  32  store data (rs2)
- mem_ready  input  1  transfer completes in any cycle with mem_req && mem_ready; may be high in the same cycle as the request
- mem_rdata  input  32  read data, valid in the completing cycle
- pc  output  32  address of the instruction in flight
- retire  output  1  one-cycle pulse in WRITEBACK
- trap  output  1  sticky; core halted

## Operation
- States: FETCH → DECODE → EXECUTE → (MEM for LW/SW) → WRITEBACK → FETCH. TRAP is terminal until reset.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready, latch mem_rdata into the IR.
- DECODE: read rs1/rs2 and build the immediate (I/S/B/U/J formats, sign-extended).
- EXECUTE:
  - ALU ops: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND plus I-forms. Shift amount uses bits [4:0] only.
  - Branch compare: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Target computation: taken branch / JAL uses pc+imm; JALR uses (rs1+imm) & ~1. All next-PC values have bits [1:0] forced to 0.
- MEM: LW/SW only, at address rs1+imm with bits [1:0] cleared. The store asserts mem_we=1 with mem_wdata=rs2. The load latches mem_rdata.
- WRITEBACK:
  - Write rd, unless rd=0. x0 always reads 0.
  - Writeback values: LUI=imm, AUIPC=pc+imm, JAL/JALR=pc+4, LW=load data, otherwise ALU result.
  - Update pc to next-PC and pulse retire.
- Supported opcodes: 0110011, 0010011, 0000011 (funct3=010 only), 0100011 (funct3=010 only), 1100011, 1101111, 1100111, 0110111, 0010111. FENCE (0001111) executes as a NOP. Everything else is illegal.
- Arithmetic is modulo 2^32. SLT is signed and SLTU is unsigned. SRA replicates bit 31.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, all registers 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, trap=0.
  - mem_req first rises in the first clock cycle after reset deasserts.
- Latency with zero-wait memory (ready high in the same cycle):
  - ALU, branch, jump, LUI, AUIPC: 4 cycles.
  - LW, SW: 5 cycles.
  - Each extra wait cycle adds exactly 1.
- Outputs are registered. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ready=0.
- Register write and pc update take effect on the WRITEBACK edge. The next FETCH uses the new pc.
- Reset mid-transfer drops mem_req immediately (asynchronous) with no completion. The register file is cleared.
- A branch to self loops forever, retiring every 4 cycles.

## Configuration
- RV_ILLEGAL_TRAP_EN defined:
  - An illegal instruction moves DECODE → TRAP: trap=1, mem_req=0, pc frozen at the offending instruction, no retire.
- RV_ILLEGAL_TRAP_EN undefined:
  - An illegal instruction is treated as a NOP: no register write, pc+4, retire pulses, trap tied to 0.

## Test plan
- ALU and writeback: program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sltu x4,x1,x2`, zero-wait memory → x3=2, x4=1, retire every 4 cycles, pc=0x10 after 16 cycles.
- Load/store: `sw` of 0xDEADBEEF to 0x100, then `lw x5,0x100(x0)`, memory ready after 3 wait cycles → write seen at 0x100, x5=0xDEADBEEF, each access 3 cycles longer.
- Branch and jump: `beq` taken with imm=-8 from pc=0x20 → pc=0x18. `jal x1,+0x40` at 0x30 → x1=0x34, pc=0x70. `jalr` with rs1=0x81, imm=0 → pc=0x80.
- x0 and shifts: `addi x0,x0,7` → x0 reads 0. `sra` of 0x80000000 by 35 → 0xF0000000.
- Illegal instruction: word 0xFFFFFFFF at 0x8 → with the macro, trap=1, pc=0x8, mem_req stays 0. Without it, pc=0xC and retire pulses.
- Reset mid-fetch: assert reset while mem_req=1, ready=0 → mem_req=0 immediately, pc=RESET_PC. Execution restarts cleanly after release.

Source files
------------

// File: rtl/multicycle_rv32_core.sv
// Multi-cycle RV32I/RV32E integer core with a unified req/ready memory bus.
// Each instruction steps FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK.
// Optional build macro RV_ILLEGAL_TRAP_EN: illegal instructions halt the core
// in TRAP instead of retiring as a NOP.
module multicycle_rv32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);

    localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, rs1v_q, rs2v_q, imm_q, result_q, npc_q;
    logic        illegal_q;
    logic        mem_req_q, mem_we_q, retire_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] rf_q [NUM_REGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  f3;
    logic [31:0] imm_d, rs1_val, rs2_val, alu_d, result_d, npc_d, npc_raw, op_b, ea;
    logic        illegal_d, use_rd, use_rs1, use_rs2, taken, wb_en;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign f7      = ir_q[31:25];

    assign rs1_val = (rs1_idx != 5'd0 && 32'(rs1_idx) < NUM_REGS) ? rf_q[rs1_idx[RW-1:0]] : '0;
    assign rs2_val = (rs2_idx != 5'd0 && 32'(rs2_idx) < NUM_REGS) ? rf_q[rs2_idx[RW-1:0]] : '0;

    // Immediate extraction for every encoding format, sign-extended
    always_comb begin
        imm_d = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
            OP_STORE:                 imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH:                imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm_d = {ir_q[31:12], 12'h000};
            OP_JAL:                   imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:                  imm_d = '0;
        endcase
    end

    // Legality check: supported opcode/funct combinations and register indices in range
    always_comb begin
        illegal_d = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OP_OP: begin
                {use_rd, use_rs1, use_rs2} = 3'b111;
                if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                    illegal_d = 1'b1;
            end
            OP_IMM: begin
                {use_rd, use_rs1} = 2'b11;
                if (f3 == 3'b001 && f7 != 7'b0000000) illegal_d = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal_d = 1'b1;
            end
            OP_LOAD: begin
                {use_rd, use_rs1} = 2'b11;
                illegal_d = (f3 != 3'b010);
            end
            OP_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                illegal_d = (f3 != 3'b010);
            end
            OP_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                illegal_d = (f3 == 3'b010 || f3 == 3'b011);
            end
            OP_JAL:           use_rd = 1'b1;
            OP_JALR: begin
                {use_rd, use_rs1} = 2'b11;
                illegal_d = (f3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: use_rd = 1'b1;
            OP_FENCE:         illegal_d = 1'b0;
            default:          illegal_d = 1'b1;
        endcase
        if (use_rd  && 32'(rd_idx)  >= NUM_REGS) illegal_d = 1'b1;
        if (use_rs1 && 32'(rs1_idx) >= NUM_REGS) illegal_d = 1'b1;
        if (use_rs2 && 32'(rs2_idx) >= NUM_REGS) illegal_d = 1'b1;
    end

    // ALU, branch compare, writeback value and next-PC from the latched operands
    always_comb begin
        op_b  = (opcode == OP_OP) ? rs2v_q : imm_q;
        alu_d = '0;
        case (f3)
            3'b000: alu_d = (opcode == OP_OP && f7[5]) ? rs1v_q - op_b : rs1v_q + op_b;
            3'b001: alu_d = rs1v_q << op_b[4:0];
            3'b010: alu_d = {31'b0, $signed(rs1v_q) < $signed(op_b)};
            3'b011: alu_d = {31'b0, rs1v_q < op_b};
            3'b100: alu_d = rs1v_q ^ op_b;
            3'b101: alu_d = f7[5] ? 32'($signed(rs1v_q) >>> op_b[4:0]) : rs1v_q >> op_b[4:0];
            3'b110: alu_d = rs1v_q | op_b;
            default: alu_d = rs1v_q & op_b;
        endcase

        case (f3)
            3'b000:  taken = (rs1v_q == rs2v_q);
            3'b001:  taken = (rs1v_q != rs2v_q);
            3'b100:  taken = ($signed(rs1v_q) < $signed(rs2v_q));
            3'b101:  taken = ($signed(rs1v_q) >= $signed(rs2v_q));
            3'b110:  taken = (rs1v_q < rs2v_q);
            3'b111:  taken = (rs1v_q >= rs2v_q);
            default: taken = 1'b0;
        endcase

        case (opcode)
            OP_LUI:          result_d = imm_q;
            OP_AUIPC:        result_d = pc_q + imm_q;
            OP_JAL, OP_JALR: result_d = pc_q + 32'd4;
            default:         result_d = alu_d;
        endcase

        ea      = rs1v_q + imm_q;
        npc_raw = pc_q + 32'd4;
        if (!illegal_q) begin
            if (opcode == OP_JAL || (opcode == OP_BRANCH && taken)) npc_raw = pc_q + imm_q;
            else if (opcode == OP_JALR)                             npc_raw = ea & ~32'd1;
        end
        npc_d = {npc_raw[31:2], 2'b00};

        wb_en = !illegal_q && rd_idx != 5'd0 &&
                (opcode == OP_OP || opcode == OP_IMM || opcode == OP_LOAD || opcode == OP_JAL ||
                 opcode == OP_JALR || opcode == OP_LUI || opcode == OP_AUIPC);
    end

`ifdef RV_ILLEGAL_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Instruction sequencer: owns pc, register file and all registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            rs1v_q      <= '0;
            rs2v_q      <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            npc_q       <= '0;
            illegal_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            rf_q        <= '{default: '0};
`ifdef RV_ILLEGAL_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    // First fetch after reset raises the request here; later fetches
                    // arrive with it already raised by WRITEBACK.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1v_q    <= rs1_val;
                    rs2v_q    <= rs2_val;
                    imm_q     <= imm_d;
                    illegal_q <= illegal_d;
`ifdef RV_ILLEGAL_TRAP_EN
                    if (illegal_d) begin
                        trap_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
`else
                    state_q <= S_EXECUTE;
`endif
                end
                S_EXECUTE: begin
                    result_q <= result_d;
                    npc_q    <= npc_d;
                    if (!illegal_q && (opcode == OP_LOAD || opcode == OP_STORE)) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= (opcode == OP_STORE);
                        mem_addr_q <= {ea[31:2], 2'b00};
                        if (opcode == OP_STORE) mem_wdata_q <= rs2v_q;
                        state_q    <= S_MEM;
                    end else begin
                        retire_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) result_q <= mem_rdata;
                        retire_q  <= 1'b1;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    retire_q   <= 1'b0;
                    if (wb_en) rf_q[rd_idx[RW-1:0]] <= result_q;
                    pc_q       <= npc_q;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= npc_q;
                    state_q    <= S_FETCH;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    retire_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;

endmodule
